layer_stream_serializer: RTL

//  Parametrised successor to the per-layer IDLE/SEND pipelining FSMs between Layer instances.

---
 rtl/layer_stream_serializer_if.sv | 28 ++
 rtl/layer_stream_serializer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/layer_stream_serializer_if.sv
// Handshake bundle between a layer's parallel output and the word-serial stream.
// The slave modport is the serializer's view; master is the producer/consumer side.
interface layer_stream_serializer_if #(
  parameter int unsigned NN         = 30,
  parameter int unsigned DATA_WIDTH = 16
);
  localparam int unsigned IW = (NN > 1) ? $clog2(NN) : 1;

  logic                       i_valid;
  logic [NN*DATA_WIDTH-1:0]   i_data;
  logic [DATA_WIDTH-1:0]      o_data;
  logic                       o_valid;
  logic                       o_ready;
  logic                       o_last;
  logic [IW-1:0]              o_index;
  logic                       o_busy;
  logic                       o_overflow;

  modport slave (
    input  i_valid, i_data, o_ready,
    output o_data, o_valid, o_last, o_index, o_busy, o_overflow
  );

  modport master (
    output i_valid, i_data, o_ready,
    input  o_data, o_valid, o_last, o_index, o_busy, o_overflow
  );
endinterface

// File: rtl/layer_stream_serializer.sv
// Captures an NN-word parallel vector and streams it one word per cycle over valid/ready,
// with an optional pending slot so the next vector can arrive while the current one streams.
module layer_stream_serializer #(
  parameter int unsigned NN            = 30,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned DOUBLE_BUFFER = 1,
  parameter int unsigned LSB_FIRST     = 1
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  input  logic                      soft_reset,
  layer_stream_serializer_if.slave  bus
);
  localparam int unsigned IW = (NN > 1) ? $clog2(NN) : 1;
  localparam int unsigned VW = NN * DATA_WIDTH;
  localparam logic [IW-1:0] LastIdx = IW'(NN - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e          state_q, state_d;
  logic [VW-1:0]   active_q, active_d;
  logic [VW-1:0]   pend_q, pend_d;
  logic            pend_full_q, pend_full_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            overflow_q, overflow_d;

  logic            fire;
  logic            last_fire;
  logic [IW-1:0]   sel;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q     <= StIdle;
      active_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      idx_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      idx_q       <= idx_d;
      overflow_q  <= overflow_d;
    end
  end

  assign fire      = (state_q == StSend) && bus.o_ready;
  assign last_fire = fire && (idx_q == LastIdx);

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    idx_d       = idx_q;
    overflow_d  = overflow_q;

    if (soft_reset) begin
      state_d     = StIdle;
      active_d    = '0;
      pend_d      = '0;
      pend_full_d = 1'b0;
      idx_d       = '0;
      overflow_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.i_valid) begin
            active_d = bus.i_data;
            idx_d    = '0;
            state_d  = StSend;
          end
        end
        StSend: begin
          if (last_fire) begin
            idx_d = '0;
            // Pending vector wins the active slot; a simultaneous arrival refills pending.
            if (pend_full_q) begin
              active_d    = pend_q;
              pend_full_d = 1'b0;
              if (bus.i_valid) begin
                pend_d      = bus.i_data;
                pend_full_d = 1'b1;
              end
            end else if (bus.i_valid) begin
              active_d = bus.i_data;
            end else begin
              state_d = StIdle;
            end
          end else begin
            if (fire) begin
              idx_d = idx_q + 1'b1;
            end
            if (bus.i_valid) begin
              if ((DOUBLE_BUFFER != 0) && !pend_full_q) begin
                pend_d      = bus.i_data;
                pend_full_d = 1'b1;
              end else begin
                overflow_d = 1'b1;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign sel = (LSB_FIRST != 0) ? idx_q : (LastIdx - idx_q);

  assign bus.o_valid    = (state_q == StSend);
  assign bus.o_data     = (state_q == StSend) ? active_q[int'(sel) * DATA_WIDTH +: DATA_WIDTH]
                                              : '0;
  assign bus.o_index    = idx_q;
  assign bus.o_last     = (state_q == StSend) && (idx_q == LastIdx);
  assign bus.o_busy     = (state_q != StIdle) || pend_full_q;
  assign bus.o_overflow = overflow_q;

endmodule
